step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
- Iteration controller for the ODE solver loop.
- Sits directly upstream of the negedge step down-counter. It loads the counter with the requested step count, fires one solver step per iteration, and decrements the counter on each step completion.
- Ends the run when the counter reads zero. A stalled step causes a timeout fault.
- Runs on the posedge. Counter outputs are Moore-decoded from state flops, so the counter samples stable values at the following negedge.

Parameters:
WORD_SIZE, 32, width of step count and counter interface
TIMEOUT, 1024, max cycles spent in WAIT before fault (>=2)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
start  input  1  pulse; begin run (ignored unless IDLE)
abort  input  1  level; terminate run, priority over start
num_steps  input  WORD_SIZE  steps to run, captured when start is accepted
count  input  WORD_SIZE  current value from down-counter
cnt_load  output  1  counter load strobe
cnt_in  output  WORD_SIZE  counter load value (= latched num_steps)
cnt_trigger  output  1  counter decrement strobe
cnt_clear  output  1  counter synchronous clear strobe
step_start  output  1  one-cycle pulse to solver datapath
step_done  input  1  datapath step complete (sampled in WAIT only)
busy  output  1  high in every state except IDLE
run_done  output  1  one-cycle pulse, run completed normally
error  output  1  sticky timeout flag; cleared on next accepted start or reset

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, latched N=0, timer=0, error=0.
  - All strobes, busy and run_done are 0. cnt_in=0.
  - Reset does not touch the counter. The next LOAD overwrites it.
- States: IDLE, LOAD, CHECK, ISSUE, WAIT, ADVANCE, FINISH, CLEAR.
- IDLE:
  - start=1 and abort=0 -> LOAD; latch N<=num_steps; error<=0.
  - Otherwise stay in IDLE.
- LOAD: cnt_load=1 -> CHECK. The counter captures at the negedge inside LOAD; count is valid in CHECK.
- CHECK: count==0 -> FINISH, else -> ISSUE.
- ISSUE: step_start=1 -> WAIT; timer<=0.
- WAIT:
  - step_done=1 -> ADVANCE.
  - Else timer==TIMEOUT-1 -> CLEAR with error<=1.
  - Else timer<=timer+1.
  - step_done wins over timeout in the same cycle.
- ADVANCE: cnt_trigger=1 -> CHECK. The decrement lands at the negedge; the new count is seen in CHECK.
- FINISH: run_done=1 -> IDLE.
- CLEAR: cnt_clear=1 -> IDLE.
- Abort:
  - abort=1 in any state other than IDLE, FINISH or CLEAR -> CLEAR next posedge. error is unchanged and run_done is not pulsed.
  - abort in FINISH or CLEAR is ignored; those states complete normally.
- Strobe decoding:
  - cnt_load, cnt_trigger, cnt_clear, step_start and run_done are pure decodes of the state register. Each is one cycle wide.
  - At most one counter strobe is high in any cycle.
- cnt_in is driven from the latched N and holds its value between runs.
- step_done outside WAIT is ignored. The datapath must hold or re-assert it only within WAIT.
- Latency:
  - Run of N steps where step_done arrives in the first WAIT cycle: 1 (LOAD) + 4N (CHECK, ISSUE, WAIT, ADVANCE) + 1 (CHECK) + 1 (FINISH) cycles after start is sampled.
  - N=0: run_done asserts in the 3rd cycle after start.
- Width rules:
  - count compare is full WORD_SIZE equality to zero.
  - N=2^WORD_SIZE-1 is legal; there is no wrap handling, since the counter never decrements below 0 (CHECK exits at zero).
  - Timer width is clog2(TIMEOUT).
- start while busy: ignored, and the latched N is unchanged.
- Reset mid-run: immediate return to IDLE with all outputs low. error is cleared.

Test Plan:
- Reset then start with num_steps=3 and step_done one cycle after each step_start:
  - Expect cnt_load once and cnt_in=3.
  - Expect 3 step_start pulses and 3 cnt_trigger pulses; count goes 3,2,1,0.
  - run_done pulses 15 cycles after start; busy is low afterwards.
- num_steps=0: cnt_load once, no step_start, run_done in 3rd cycle after start, error=0.
- TIMEOUT=8, num_steps=2, step_done never asserted:
  - Expect exactly 1 step_start and 8 WAIT cycles.
  - Then a cnt_clear pulse, error=1 sticky, no run_done.
  - The next start clears error.
- num_steps=5 with abort asserted in the second WAIT: CLEAR next cycle, cnt_clear=1, busy drops, run_done=0, error=0.
- Edge cases:
  - step_done and the timer-expiry cycle coincide (TIMEOUT=4, done on the 4th WAIT cycle) -> ADVANCE, no error.
  - start pulsed mid-run with num_steps=9 -> ignored, cnt_in stays at the original value.
  - start and abort together in IDLE -> remain IDLE.
- Assert rst low mid-WAIT -> outputs 0 asynchronously. Release, then start with num_steps=1 -> normal completion.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: ODE solver iteration controller driving a negedge step down-counter
module step_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WORD_SIZE-1:0] num_steps,
    input  logic [WORD_SIZE-1:0] count,
    output logic                 cnt_load,
    output logic [WORD_SIZE-1:0] cnt_in,
    output logic                 cnt_trigger,
    output logic                 cnt_clear,
    output logic                 step_start,
    input  logic                 step_done,
    output logic                 busy,
    output logic                 run_done,
    output logic                 error
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, ISSUE, WAIT, ADVANCE, FINISH, CLEAR} state_t;
    state_t state_q, state_d;
    logic [WORD_SIZE-1:0] n_q, n_d;
    logic [TW-1:0] timer_q, timer_d;
    logic err_q, err_d;
    assign cnt_in = n_q;
    assign error  = err_q;
    // next state; abort overrides every decision of the active states and leaves error untouched
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d = LOAD;
                n_d     = num_steps;
                err_d   = 1'b0;
            end
            LOAD:    state_d = CHECK;
            CHECK:   state_d = (count == '0) ? FINISH : ISSUE;
            ISSUE: begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: if (step_done) state_d = ADVANCE;
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = CLEAR;
                    err_d   = 1'b1;
                end else timer_d = timer_q + 1'b1;
            ADVANCE: state_d = CHECK;
            default: state_d = IDLE;
        endcase
        if (abort && state_q inside {LOAD, CHECK, ISSUE, WAIT, ADVANCE}) begin
            state_d = CLEAR;
            err_d   = err_q;
        end
    end
    // state registers; strobes are registered decodes of the next state so they track state_q exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            cnt_load    <= 1'b0;
            cnt_trigger <= 1'b0;
            cnt_clear   <= 1'b0;
            step_start  <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            cnt_load    <= state_d == LOAD;
            cnt_trigger <= state_d == ADVANCE;
            cnt_clear   <= state_d == CLEAR;
            step_start  <= state_d == ISSUE;
            busy        <= state_d != IDLE;
            run_done    <= state_d == FINISH;
        end
    end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: scoreboarded run scenarios against a behavioural negedge down-counter
module tb_step_sequencer;
    localparam int W  = 16;
    localparam int TO = 8;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, step_done = 1'b0;
    logic [W-1:0] num_steps = '0, count = '0, cnt_in, load_val;
    logic cnt_load, cnt_trigger, cnt_clear, step_start, busy, run_done, error;
    typedef struct {
        logic [W-1:0] n;
        int dly;
        int ab;
        int ms;
        int end_c;
        int steps;
        int trigs;
        bit rd;
        bit err;
    } vec_t;
    vec_t vecs[6];
    vec_t sb[$];
    int checks = 0, errors = 0;
    int cyc, wc, loads, steps, trigs, clears, rdones, multi, end_cyc, dly, ab;

    step_sequencer #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps),
        .count(count), .cnt_load(cnt_load), .cnt_in(cnt_in), .cnt_trigger(cnt_trigger),
        .cnt_clear(cnt_clear), .step_start(step_start), .step_done(step_done),
        .busy(busy), .run_done(run_done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance to the next negedge, observe strobes, model the counter and the datapath
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cnt_load) begin
            loads++;
            load_val = cnt_in;
        end
        if (step_start) steps++;
        if (cnt_trigger) trigs++;
        if (cnt_clear) clears++;
        if (run_done) rdones++;
        if (int'(cnt_load) + int'(cnt_trigger) + int'(cnt_clear) > 1) multi++;
        if (end_cyc == 0 && (run_done || cnt_clear)) end_cyc = cyc;
        if (cnt_clear) count = '0;
        else if (cnt_load) count = cnt_in;
        else if (cnt_trigger) count = count - 1'b1;
        step_done = 1'b0;
        abort = 1'b0;
        if (step_start) wc = 0;
        else if (wc >= 0) wc++;
        if (wc > 0) begin
            if (steps == ab) begin
                if (wc == 1) abort = 1'b1;
            end else if (wc == dly) begin
                step_done = 1'b1;
                wc = -1;
            end
        end
    endtask

    task automatic run(input vec_t v);
        vec_t e;
        cyc = 0; wc = -1; loads = 0; steps = 0; trigs = 0; clears = 0;
        rdones = 0; multi = 0; end_cyc = 0; dly = v.dly; ab = v.ab;
        sb.push_back(v);
        num_steps = v.n;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (end_cyc == 0 && cyc < 200) begin
            start = (cyc == v.ms);
            num_steps = (v.ms != 0 && cyc >= v.ms) ? W'(9) : v.n;
            tick();
        end
        start = 1'b0;
        tick();
        e = sb.pop_front();
        chk("run_ended", longint'(end_cyc != 0), 1);
        chk("end_cycle", end_cyc, e.end_c);
        chk("loads", loads, 1);
        chk("load_val", load_val, e.n);
        chk("step_starts", steps, e.steps);
        chk("triggers", trigs, e.trigs);
        chk("run_dones", rdones, longint'(e.rd));
        chk("clears", clears, longint'(!e.rd));
        chk("one_cnt_strobe", multi, 0);
        chk("busy_after", busy, 0);
        chk("error_after", error, longint'(e.err));
        chk("count_after", count, 0);
        chk("cnt_in_held", cnt_in, e.n);
    endtask

    initial begin
        vecs[0] = '{16'd3, 1, 0, 0, 15, 3, 3, 1'b1, 1'b0};
        vecs[1] = '{16'd0, 1, 0, 0, 3, 0, 0, 1'b1, 1'b0};
        vecs[2] = '{16'd2, 0, 0, 0, 12, 1, 0, 1'b0, 1'b1};
        vecs[3] = '{16'd5, 1, 2, 0, 9, 2, 1, 1'b0, 1'b0};
        vecs[4] = '{16'd1, 8, 0, 0, 14, 1, 1, 1'b1, 1'b0};
        vecs[5] = '{16'd4, 2, 0, 6, 23, 4, 4, 1'b1, 1'b0};
        count = 16'd77;
        repeat (2) @(negedge clk);
        chk("reset_outs", {busy, cnt_load, cnt_trigger, cnt_clear, step_start, run_done, error}, 0);
        chk("reset_cnt_in", cnt_in, 0);
        rst = 1'b1;
        @(negedge clk);
        num_steps = 16'd7;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_cnt_in", cnt_in, 0);
        @(negedge clk);
        chk("start_abort_load", cnt_load, 0);
        for (int i = 0; i < 6; i++) begin
            run(vecs[i]);
            if (vecs[i].err) begin
                repeat (3) @(negedge clk);
                chk("error_sticky", error, 1);
            end
        end
        cyc = 0; wc = -1; dly = 0; ab = 0; end_cyc = 0;
        num_steps = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outs", {busy, cnt_load, cnt_trigger, cnt_clear, step_start, run_done, error}, 0);
        chk("async_reset_cnt_in", cnt_in, 0);
        @(negedge clk);
        rst = 1'b1;
        run('{16'd1, 1, 0, 0, 7, 1, 1, 1'b1, 1'b0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
